// File: rtl/nco_note_sequencer_pkg.sv
// Shared definitions for the NCO note sequencer and its neighbouring nco block.
// Latency: n/a (types, default widths and helpers only).
// Backpressure: n/a.
package nco_note_sequencer_pkg;

    localparam int DEF_FREQ_WIDTH = 15;
    localparam int DEF_DUR_WIDTH  = 24;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_GAP_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_GAP   = 2'd3
    } seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nco_note_sequencer_note_fifo.sv
// First-word-fall-through note queue with occupancy count and synchronous clear.
// Latency: a pushed word is visible at head_dat_o the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; clear wins over both.
module note_fifo
    import nco_note_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign do_push    = push_i && !full_o && !clear_i;
    assign do_pop     = pop_i && !empty_o && !clear_i;

    // Storage array: no reset needed, occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/nco_note_sequencer.sv
// Plays queued (frequency, duration) notes by driving an nco frequency word, with pause, gap and flush.
// Latency: a note pushed into an empty idle queue is heard from the second edge after the push.
// Backpressure: note_ready drops when the queue is full or flush is high.
module nco_note_sequencer
    import nco_note_sequencer_pkg::*;
#(
    parameter int FREQ_WIDTH = DEF_FREQ_WIDTH,
    parameter int DUR_WIDTH  = DEF_DUR_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  note_valid,
    output logic                  note_ready,
    input  logic [FREQ_WIDTH-1:0] note_freq,
    input  logic [DUR_WIDTH-1:0]  note_dur,
    input  logic                  enable,
    input  logic                  flush,
    output logic [FREQ_WIDTH-1:0] nco_frequency,
    output logic                  note_active,
    output logic                  note_done,
    output logic [CW-1:0]         fifo_count
);

    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int CNT_W = max_int(DUR_WIDTH, GAP_W);
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    seq_state_e              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [FREQ_WIDTH-1:0]   freq_q;
    logic [FREQ_WIDTH-1:0]   nco_q;
    logic                    done_q;
    logic                    ready_q;

    logic [FREQ_WIDTH+DUR_WIDTH-1:0] head_dat;
    logic [FREQ_WIDTH-1:0]   head_freq;
    logic [DUR_WIDTH-1:0]    head_dur;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;

    assign {head_freq, head_dur} = head_dat;
    assign note_ready    = ready_q && !fifo_full && !flush;
    assign push          = note_valid && note_ready;
    assign pop           = (state_q == ST_IDLE) && !fifo_empty && enable && !flush;
    assign nco_frequency = nco_q;
    assign note_done     = done_q;
    assign note_active   = (state_q == ST_PLAY) || (state_q == ST_PAUSE);

    note_fifo #(
        .WIDTH (FREQ_WIDTH + DUR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_note_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (flush),
        .push_i     (push),
        .push_dat_i ({note_freq, note_dur}),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .count_o    (fifo_count)
    );

    // Holds note_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Sequencer FSM. The cycle in which enable falls was already audible, so it is
    // charged to the note; the resume edge restores the tone without charging.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            freq_q  <= '0;
            nco_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                nco_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (pop && (head_dur != '0)) begin
                            freq_q  <= head_freq;
                            nco_q   <= head_freq;
                            cnt_q   <= CNT_W'(head_dur) - CNT_W'(1);
                            state_q <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (cnt_q == '0) begin
                            done_q <= 1'b1;
                            nco_q  <= '0;
                            if (GAP_CYCLES > 0) begin
                                cnt_q   <= GAP_LOAD;
                                state_q <= ST_GAP;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                            if (!enable) begin
                                nco_q   <= '0;
                                state_q <= ST_PAUSE;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (enable) begin
                            nco_q   <= freq_q;
                            state_q <= ST_PLAY;
                        end
                    end
                    ST_GAP: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        nco_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nco_note_sequencer.sv
// Scoreboard bench: accepted notes go into an expected queue; a monitor measures audible time per note.
// Latency: n/a.
// Backpressure: stimulus only counts a note as queued when note_ready was high at the edge.
module tb_nco_note_sequencer;

    localparam int FW    = 15;
    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int GAP   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          note_valid;
    logic          note_ready;
    logic [FW-1:0] note_freq;
    logic [DW-1:0] note_dur;
    logic          enable;
    logic          flush;
    logic [FW-1:0] nco_frequency;
    logic          note_active;
    logic          note_done;
    logic [2:0]    fifo_count;

    typedef struct {
        int freq;
        int dur;
    } note_t;

    note_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    abort    = 1'b0;

    always #5 clk = ~clk;

    nco_note_sequencer #(
        .FREQ_WIDTH (FW),
        .DUR_WIDTH  (DW),
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .note_valid    (note_valid),
        .note_ready    (note_ready),
        .note_freq     (note_freq),
        .note_dur      (note_dur),
        .enable        (enable),
        .flush         (flush),
        .nco_frequency (nco_frequency),
        .note_active   (note_active),
        .note_done     (note_done),
        .fifo_count    (fifo_count)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_sample();
        @(posedge clk);
        #1;
    endtask

    // Offer one note for one edge; returns whether it was accepted.
    task automatic offer(input int f, input int d, output bit acc);
        @(negedge clk);
        note_valid = 1'b1;
        note_freq  = FW'(f);
        note_dur   = DW'(d);
        #4;
        acc = note_ready;
        if (acc && d != 0) exp_q.push_back('{f, d});
        @(posedge clk);
        #1;
        note_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 2000; i++) begin
            wait_sample();
            if (note_done) break;
        end
        chk(name, note_done, 1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20000; i++) begin
            wait_sample();
            if (exp_q.size() == 0 && fifo_count == 0 && !note_active) break;
        end
        chk(name, exp_q.size(), 0);
        repeat (GAP + 2) wait_sample();
    endtask

    // Monitor: every audible cycle must carry the head note's frequency; on note_done the
    // audible time must equal the note's duration; silence before the next note covers the gap.
    initial begin : monitor
        int    hi_cnt;
        int    silent;
        bit    after_done;
        note_t n;
        hi_cnt = 0;
        silent = 0;
        after_done = 1'b0;
        forever begin
            wait_sample();
            if (abort) begin
                hi_cnt = 0;
                silent = 0;
                after_done = 1'b0;
                abort = 1'b0;
            end
            if (nco_frequency != 0) begin
                if (after_done) begin
                    chk("gap_len_at_least", silent >= GAP + 1, 1);
                    after_done = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_tone", nco_frequency, 0);
                end else begin
                    chk("tone_freq", nco_frequency, exp_q[0].freq);
                    hi_cnt++;
                end
            end else if (after_done) begin
                silent++;
            end
            if (note_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", note_done, 0);
                end else begin
                    n = exp_q.pop_front();
                    chk("note_len", hi_cnt, n.dur);
                end
                hi_cnt = 0;
                silent = 1;
                after_done = 1'b1;
            end
        end
    end

    initial begin : stimulus
        bit acc;
        int zeros;
        int hits;
        rst        = 1'b1;
        note_valid = 1'b0;
        note_freq  = '0;
        note_dur   = '0;
        enable     = 1'b1;
        flush      = 1'b0;

        // Reset state
        #12;
        chk("rst_nco", nco_frequency, 0);
        chk("rst_active", note_active, 0);
        chk("rst_done", note_done, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", note_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_sample();
        chk("ready_after_release", note_ready, 1);

        // Single note: tone from the second edge after push, then silence
        offer(20000, 100, acc);
        chk("n1_acc", acc, 1);
        chk("n1_silent_after_push", nco_frequency, 0);
        chk("n1_count_after_push", fifo_count, 1);
        wait_sample();
        chk("n1_tone_start", nco_frequency, 20000);
        chk("n1_active", note_active, 1);
        wait_done("n1_done");
        chk("n1_silent_at_done", nco_frequency, 0);
        zeros = 0;
        hits  = 0;
        for (int i = 0; i < GAP; i++) begin
            wait_sample();
            if (nco_frequency == 0) zeros++;
            if (note_done) hits++;
        end
        chk("n1_gap_silent", zeros, GAP);
        chk("n1_single_pulse", hits, 0);
        wait_drain("n1_drain");

        // Fill the queue while paused; the fifth waits for the first pop
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offer(1100 + i * 100, 6 + i, acc);
            chk("fill_acc", acc, 1);
        end
        @(negedge clk);
        note_valid = 1'b1;
        note_freq  = FW'(1900);
        note_dur   = DW'(7);
        #4;
        chk("full_ready_low", note_ready, 0);
        chk("full_count", fifo_count, DEPTH);
        enable = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) offer(1900, 7, acc);
        chk("fifth_accepted", acc, 1);
        wait_drain("fill_drain");

        // Pause for 30 cycles after 40 audible cycles
        offer(3000, 100, acc);
        for (int i = 0; i < 20 && nco_frequency == 0; i++) wait_sample();
        chk("pause_tone_start", nco_frequency, 3000);
        repeat (39) wait_sample();
        @(negedge clk);
        enable = 1'b0;
        zeros = 0;
        repeat (30) begin
            wait_sample();
            if (nco_frequency == 0) zeros++;
        end
        chk("pause_silent", zeros, 30);
        chk("pause_active", note_active, 1);
        @(negedge clk);
        enable = 1'b1;
        wait_sample();
        chk("pause_resume", nco_frequency, 3000);
        wait_done("pause_done");
        wait_drain("pause_drain");

        // Flush mid-note with three queued and a note offered
        offer(500, 50, acc);
        wait_sample();
        offer(600, 5, acc);
        offer(700, 5, acc);
        offer(800, 5, acc);
        chk("flush_queued", fifo_count, 3);
        @(negedge clk);
        note_valid = 1'b1;
        note_freq  = FW'(900);
        note_dur   = DW'(5);
        flush      = 1'b1;
        exp_q.delete();
        abort      = 1'b1;
        #4;
        chk("flush_ready_low", note_ready, 0);
        wait_sample();
        chk("flush_count", fifo_count, 0);
        chk("flush_nco", nco_frequency, 0);
        chk("flush_active", note_active, 0);
        chk("flush_done", note_done, 0);
        @(negedge clk);
        flush      = 1'b0;
        note_valid = 1'b0;
        hits = 0;
        repeat (60) begin
            wait_sample();
            if (note_done || nco_frequency != 0) hits++;
        end
        chk("flush_quiet", hits, 0);
        chk("flush_push_ignored", fifo_count, 0);

        // Zero-duration note is skipped; same-edge push and pop keep the count
        offer(7, 0, acc);
        offer(1000, 10, acc);
        chk("zero_dur_count", fifo_count, 1);
        chk("zero_dur_silent", nco_frequency, 0);
        chk("zero_dur_inactive", note_active, 0);
        wait_done("zero_dur_next_done");
        wait_drain("zero_dur_drain");

        // Asynchronous reset mid-note
        offer(9000, 40, acc);
        offer(9100, 5, acc);
        offer(9200, 5, acc);
        repeat (10) wait_sample();
        #2;
        rst = 1'b1;
        exp_q.delete();
        abort = 1'b1;
        #1;
        chk("arst_nco", nco_frequency, 0);
        chk("arst_active", note_active, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_ready", note_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        repeat (50) begin
            wait_sample();
            if (nco_frequency != 0 || note_done) hits++;
        end
        chk("arst_lost", hits, 0);
        chk("arst_queue_empty", fifo_count, 0);

        // Randomized traffic with pauses and occasional flushes
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            note_valid = ($urandom_range(0, 3) == 0);
            note_freq  = FW'($urandom_range(1, 32767));
            note_dur   = ($urandom_range(0, 7) == 0) ? DW'(0) : DW'($urandom_range(1, 24));
            enable     = ($urandom_range(0, 9) != 0);
            flush      = ($urandom_range(0, 199) == 0);
            if (flush) begin
                exp_q.delete();
                abort = 1'b1;
            end
            #4;
            if (note_valid && note_ready && note_dur != 0)
                exp_q.push_back('{int'(note_freq), int'(note_dur)});
        end
        @(negedge clk);
        note_valid = 1'b0;
        flush      = 1'b0;
        enable     = 1'b1;
        wait_drain("random_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
